ofifo_drain_ctrl: RTL and testbench

- Consumer side of the core's output FIFO. Pops post-SFP partial-sum rows (ofifo_valid / sfp_out) and writes each row as one word into the psum SRAM (sram_128b_w2048-style active-low CEN/WEN port) at consecutive addresses.
- Drains a programmed number of rows per job, then pulses done.
- Sits between core's ofifo/sfp_out and the psum SRAM.

---
 rtl/ofifo_drain_ctrl_if.sv | 22 ++
 rtl/ofifo_drain_ctrl.sv | 65 ++++++
 tb/tb_ofifo_drain_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ofifo_drain_ctrl_if.sv
// ofifo_drain_ctrl_if: FIFO-head and psum SRAM write port bundle.
interface ofifo_drain_ctrl_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_w  = 11
);
   logic                     ofifo_valid;
   logic [col*psum_bw-1:0]   sfp_out;
   logic                     ofifo_rd;
   logic                     sram_CEN;
   logic                     sram_WEN;
   logic [addr_w-1:0]        sram_A;
   logic [col*psum_bw-1:0]   sram_D;
   modport master (
      input  ofifo_valid, sfp_out,
      output ofifo_rd, sram_CEN, sram_WEN, sram_A, sram_D
   );
   modport slave (
      output ofifo_valid, sfp_out,
      input  ofifo_rd, sram_CEN, sram_WEN, sram_A, sram_D
   );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: pops num_rows rows from the output FIFO into consecutive psum SRAM words.
module ofifo_drain_ctrl #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_w  = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [addr_w-1:0]   base_addr,
   input  logic [addr_w:0]     num_rows,
   ofifo_drain_ctrl_if.master  bus,
   output logic                busy,
   output logic                done,
   output logic [addr_w:0]     rows_left
);
   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
   state_t                 state;
   logic [addr_w-1:0]      wr_ptr;
   logic [col*psum_bw-1:0] head;
   assign head = bus.sfp_out;
   assign bus.ofifo_rd = (state == DRAIN) && bus.ofifo_valid && (rows_left != '0);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rows_left    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         bus.sram_CEN <= 1'b1;
         bus.sram_WEN <= 1'b1;
         bus.sram_A   <= '0;
         bus.sram_D   <= '0;
      end else begin
         bus.sram_CEN <= !bus.ofifo_rd;
         bus.sram_WEN <= !bus.ofifo_rd;
         if (bus.ofifo_rd) begin
            bus.sram_A <= wr_ptr;
            bus.sram_D <= head;
            wr_ptr     <= wr_ptr + 1'b1;
            rows_left  <= rows_left - 1'b1;
         end
         // The final pop moves to DONE so done lines up with the last SRAM write.
         case (state)
            IDLE: if (start) begin
               wr_ptr    <= base_addr;
               rows_left <= num_rows;
               busy      <= 1'b1;
               done      <= (num_rows == '0);
               state     <= (num_rows == '0) ? DONE : DRAIN;
            end
            DRAIN: if (bus.ofifo_rd && rows_left == 1) begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb_ofifo_drain_ctrl: directed jobs against a FIFO model and an address/data scoreboard.
module tb_ofifo_drain_ctrl;
   logic         clk, reset, start, busy, done;
   logic [10:0]  base_addr;
   logic [11:0]  num_rows, rows_left;
   logic [127:0] fifo_q[$];
   logic [138:0] exp_q[$];
   bit           gate_q[$];
   logic         rd_d;
   int           tests, fails, pop_cnt, wr_cnt, done_cnt, busy_cnt, cyc;

   ofifo_drain_ctrl_if #(.col(8), .psum_bw(16), .addr_w(11)) bus ();
   ofifo_drain_ctrl #(.col(8), .psum_bw(16), .addr_w(11)) u_dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .bus(bus.master), .busy(busy), .done(done), .rows_left(rows_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #2;
   endtask

   // FIFO model: pops on the edge after a sampled ofifo_rd, then presents the new head.
   always @(posedge clk) begin
      bit g;
      #1;
      if (rd_d && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rd_d = 1'b0;
      g = (gate_q.size() > 0) ? gate_q.pop_front() : 1'b1;
      bus.ofifo_valid = g && (fifo_q.size() > 0);
      bus.sfp_out = (fifo_q.size() > 0) ? fifo_q[0] : '0;
   end

   always @(negedge clk) if (reset) begin
      logic [138:0] e;
      rd_d = bus.ofifo_rd;
      if (bus.ofifo_rd) begin
         pop_cnt++;
         chk("rd_needs_valid", bus.ofifo_valid, 1'b1);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (!bus.sram_CEN) begin
         wr_cnt++;
         chk("wen_eq_cen", bus.sram_WEN, bus.sram_CEN);
         chk("write_expected", bus.sram_CEN, exp_q.size() == 0);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.sram_A, e[138:128]);
            chk("wr_data", bus.sram_D, e[127:0]);
            chk("done_align", done, exp_q.size() == 0);
         end
      end
   end

   task automatic launch(input logic [10:0] b, input logic [11:0] n);
      for (int i = 0; i < n; i++) begin
         logic [127:0] r;
         logic [10:0]  a;
         r = {$urandom, $urandom, $urandom, $urandom};
         a = b + 11'(i);
         fifo_q.push_back(r);
         exp_q.push_back({a, r});
      end
      pop_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
      base_addr = b; num_rows = n; start = 1'b1;
      step;
      start = 1'b0;
   endtask

   task automatic finish_job(input int n, input int exp_busy, input int max, output int c);
      c = 1;
      while (!done && c < max) begin
         step;
         c++;
      end
      chk("done_seen", done, 1'b1);
      chk("pop_count", pop_cnt, n);
      chk("write_count", wr_cnt, n);
      chk("done_count", done_cnt, 1);
      chk("busy_cycles", busy_cnt, exp_busy);
      step;
      chk("idle_after_done", busy, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      tests = 0; fails = 0; rd_d = 1'b0;
      reset = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
      bus.ofifo_valid = 1'b0; bus.sfp_out = '0;
      step; step;
      chk("rst_rd", bus.ofifo_rd, 1'b0);
      chk("rst_cen", bus.sram_CEN, 1'b1);
      chk("rst_wen", bus.sram_WEN, 1'b1);
      chk("rst_addr", bus.sram_A, 0);
      chk("rst_data", bus.sram_D, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rows_left", rows_left, 0);
      reset = 1'b1;
      step;

      // basic burst
      launch(11'h010, 12'd4);
      chk("burst_first_rd", bus.ofifo_rd, 1'b1);
      chk("burst_rows_left", rows_left, 4);
      chk("burst_busy", busy, 1'b1);
      step; step; step;
      chk("burst_consecutive", pop_cnt, 4);
      finish_job(4, 5, 50, cyc);

      // bubbles in ofifo_valid
      gate_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      launch(11'h080, 12'd3);
      finish_job(3, 7, 50, cyc);
      chk("bubble_done_cycle", cyc, 7);

      // address wrap
      launch(11'd2046, 12'd4);
      finish_job(4, 5, 50, cyc);

      // zero length
      launch(11'h055, 12'd0);
      chk("zero_done", done, 1'b1);
      chk("zero_rd", bus.ofifo_rd, 1'b0);
      finish_job(0, 1, 10, cyc);

      // start while busy is ignored
      launch(11'h020, 12'd5);
      step;
      base_addr = 11'h100; num_rows = 12'd2; start = 1'b1;
      step;
      start = 1'b0;
      finish_job(5, 6, 50, cyc);
      step; step;
      chk("ignored_start_idle", busy, 1'b0);

      // full depth
      launch(11'd0, 12'd2048);
      chk("full_rows_left_start", rows_left, 2048);
      finish_job(2048, 2049, 3000, cyc);
      chk("full_done_cycle", cyc, 2049);
      chk("full_rows_left_end", rows_left, 0);

      // reset during the third pop
      launch(11'h040, 12'd8);
      cyc = 0;
      while (pop_cnt < 3 && cyc < 20) begin
         step;
         cyc++;
      end
      chk("midrst_third_pop", pop_cnt, 3);
      reset = 1'b0;
      #1;
      chk("midrst_cen", bus.sram_CEN, 1'b1);
      chk("midrst_wen", bus.sram_WEN, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rows_left", rows_left, 0);
      chk("midrst_rd", bus.ofifo_rd, 1'b0);
      fifo_q.delete(); exp_q.delete(); gate_q.delete(); rd_d = 1'b0;
      step; step;
      reset = 1'b1;
      step;
      launch(11'h300, 12'd3);
      finish_job(3, 4, 50, cyc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
